// File: rtl/oflow_loader_pkg.sv
// Types shared by the frame loader and its bbox buffer.
`ifndef BBOX_VECTOR_SIZE
`define BBOX_VECTOR_SIZE 32
`endif

package oflow_loader_pkg;

  // Loader control states: collect beats, pulse start, hold for the tracker.
  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } loader_state_t;

  // One bounding-box word at the project-wide width.
  typedef logic [`BBOX_VECTOR_SIZE-1:0] bbox_t;

endpackage

// File: rtl/oflow_bbox_buffer.sv
// Per-frame bbox register array: one write port, synchronous clear, all entries visible.
module oflow_bbox_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_N,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr,
  output logic [WIDTH-1:0] entries [0:DEPTH-1]
);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];

  // Clear wins over write so a finished frame always leaves an all-zero array.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign entries = mem_q;

endmodule

// File: rtl/oflow_core_define.sv
// Shared width constants for the optical-flow datapath.
`ifndef BBOX_VECTOR_SIZE
`define BBOX_VECTOR_SIZE 32
`endif
`ifndef MAX_BBOXES_PER_FRAME
`define MAX_BBOXES_PER_FRAME 4
`endif

// File: rtl/oflow_frame_loader.sv
// Frame loader: packs streamed bboxes into a frame array, launches the tracker,
// and holds the array until the tracker reports done.
`ifndef BBOX_VECTOR_SIZE
`define BBOX_VECTOR_SIZE 32
`endif
`ifndef MAX_BBOXES_PER_FRAME
`define MAX_BBOXES_PER_FRAME 4
`endif

module oflow_frame_loader
  import oflow_loader_pkg::*;
#(
  parameter int BBOX_VECTOR_SIZE     = `BBOX_VECTOR_SIZE,
  parameter int MAX_BBOXES_PER_FRAME = `MAX_BBOXES_PER_FRAME,
  parameter int CNT_W                = $clog2(MAX_BBOXES_PER_FRAME + 1),
  parameter int FRAME_CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        reset_N,
  input  logic [BBOX_VECTOR_SIZE-1:0] in_bbox,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [BBOX_VECTOR_SIZE-1:0] bboxes_array_per_frame [0:MAX_BBOXES_PER_FRAME-1],
  output logic [CNT_W-1:0]            num_of_bboxes,
  output logic                        start,
  input  logic                        done_frame,
  output logic                        frame_overflow,
  output logic [FRAME_CNT_W-1:0]      frame_cnt
);

  localparam int              IDX_W   = (MAX_BBOXES_PER_FRAME > 1) ? $clog2(MAX_BBOXES_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BBOXES_PER_FRAME);

  loader_state_t          state_q, state_d;
  logic [CNT_W-1:0]       count_q;
  logic                   overflow_q;
  logic                   start_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic accept;
  logic room;
  logic wr_en;
  logic clr;
  logic last_accepted;

  assign in_ready      = (state_q == LOAD);
  assign accept        = in_valid && in_ready;
  assign room          = (count_q < MAX_CNT);
  assign wr_en         = accept && room;
  assign last_accepted = accept && in_last;
  assign clr           = (state_q == WAIT_DONE) && done_frame;

  // Next-state decode; done_frame only matters while waiting on the tracker.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:      if (last_accepted) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: if (done_frame) state_d = LOAD;
      default:   state_d = LOAD;
    endcase
  end

  // Control registers; start and frame_cnt update on entry to LAUNCH so both are
  // visible during the launch cycle itself.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q     <= LOAD;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      start_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= last_accepted;
      if (last_accepted) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      if (clr) begin
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (accept) begin
        if (room) count_q <= count_q + CNT_W'(1);
        else      overflow_q <= 1'b1;
      end
    end
  end

  oflow_bbox_buffer #(
    .WIDTH (BBOX_VECTOR_SIZE),
    .DEPTH (MAX_BBOXES_PER_FRAME),
    .IDX_W (IDX_W)
  ) u_buffer (
    .clk     (clk),
    .reset_N (reset_N),
    .wr_en   (wr_en),
    .wr_idx  (count_q[IDX_W-1:0]),
    .wr_data (in_bbox),
    .clr     (clr),
    .entries (bboxes_array_per_frame)
  );

  assign num_of_bboxes  = count_q;
  assign start          = start_q;
  assign frame_overflow = overflow_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_oflow_frame_loader.sv
// Directed bench for oflow_frame_loader with a 4-deep array and 2-bit frame counter.
module tb_oflow_frame_loader;

  localparam int W  = 16;
  localparam int MX = 4;
  localparam int CW = 3;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          reset_N;
  logic [W-1:0]  in_bbox;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [W-1:0]  arr [0:MX-1];
  logic [CW-1:0] num;
  logic          start;
  logic          done_frame;
  logic          ovf;
  logic [FW-1:0] fcnt;

  int nAssert = 0;
  int nFail   = 0;

  oflow_frame_loader #(
    .BBOX_VECTOR_SIZE     (W),
    .MAX_BBOXES_PER_FRAME (MX),
    .CNT_W                (CW),
    .FRAME_CNT_W          (FW)
  ) dut (
    .clk                    (clk),
    .reset_N                (reset_N),
    .in_bbox                (in_bbox),
    .in_valid               (in_valid),
    .in_last                (in_last),
    .in_ready               (in_ready),
    .bboxes_array_per_frame (arr),
    .num_of_bboxes          (num),
    .start                  (start),
    .done_frame             (done_frame),
    .frame_overflow         (ovf),
    .frame_cnt              (fcnt)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Advance one edge and settle 1 ns past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one valid beat for a single edge.
  task automatic applyStimulus(input logic [W-1:0] data, input logic last);
    in_valid = 1'b1;
    in_bbox  = data;
    in_last  = last;
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulseDone();
    done_frame = 1'b1;
    cyc();
    done_frame = 1'b0;
  endtask

  task automatic checkArray(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input logic [W-1:0] e2, input logic [W-1:0] e3);
    checkOutput({tag, "_s0"}, 32'(arr[0]), 32'(e0));
    checkOutput({tag, "_s1"}, 32'(arr[1]), 32'(e1));
    checkOutput({tag, "_s2"}, 32'(arr[2]), 32'(e2));
    checkOutput({tag, "_s3"}, 32'(arr[3]), 32'(e3));
  endtask

  task automatic doReset();
    #2;
    reset_N = 1'b0;
    cyc();
    cyc();
    reset_N = 1'b1;
  endtask

  logic [FW-1:0] expCnt [0:4];

  initial begin
    reset_N    = 1'b0;
    in_bbox    = '0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    done_frame = 1'b0;
    cyc();
    cyc();

    // Reset values
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_start", 32'(start), 32'd0);
    checkOutput("rst_num",   32'(num), 32'd0);
    checkOutput("rst_ovf",   32'(ovf), 32'd0);
    checkOutput("rst_fcnt",  32'(fcnt), 32'd0);
    checkArray("rst", 16'h0, 16'h0, 16'h0, 16'h0);
    reset_N = 1'b1;
    cyc();

    // 1: three beats, no stalls
    applyStimulus(16'hA00A, 1'b0);
    checkOutput("t1_num_after_A", 32'(num), 32'd1);
    checkOutput("t1_noStartEarly", 32'(start), 32'd0);
    applyStimulus(16'hB00B, 1'b0);
    applyStimulus(16'hC00C, 1'b1);
    checkOutput("t1_start", 32'(start), 32'd1);
    checkOutput("t1_ready_launch", 32'(in_ready), 32'd0);
    checkOutput("t1_num", 32'(num), 32'd3);
    checkArray("t1", 16'hA00A, 16'hB00B, 16'hC00C, 16'h0);
    in_valid = 1'b1;
    in_bbox  = 16'hDEAD;
    cyc();
    checkOutput("t1_start_one_cycle", 32'(start), 32'd0);
    checkOutput("t1_fcnt", 32'(fcnt), 32'd1);
    cyc();
    cyc();
    checkOutput("t1_ready_wait", 32'(in_ready), 32'd0);
    checkOutput("t1_num_hold", 32'(num), 32'd3);
    checkOutput("t1_s3_hold", 32'(arr[3]), 32'd0);
    in_valid = 1'b0;
    pulseDone();
    checkOutput("t1_ready_after_done", 32'(in_ready), 32'd1);
    checkOutput("t1_num_cleared", 32'(num), 32'd0);
    checkArray("t1_clr", 16'h0, 16'h0, 16'h0, 16'h0);

    // 2: in_valid toggling; in_last with in_valid low is ignored
    applyStimulus(16'h0D0D, 1'b0);
    in_bbox = 16'hBAD1;
    cyc();
    applyStimulus(16'h0E0E, 1'b0);
    in_bbox = 16'hBAD2;
    in_last = 1'b1;
    cyc();
    in_last = 1'b0;
    checkOutput("t2_lastIgnored", 32'(in_ready), 32'd1);
    checkOutput("t2_num_mid", 32'(num), 32'd2);
    applyStimulus(16'h0F0F, 1'b1);
    checkOutput("t2_start", 32'(start), 32'd1);
    checkOutput("t2_num", 32'(num), 32'd3);
    checkArray("t2", 16'h0D0D, 16'h0E0E, 16'h0F0F, 16'h0);
    cyc();
    checkOutput("t2_fcnt", 32'(fcnt), 32'd2);
    pulseDone();

    // 3: six beats overflow a 4-deep frame
    for (int i = 1; i <= 4; i++) applyStimulus(16'(16'h0100 + i), 1'b0);
    checkOutput("t3_num_full", 32'(num), 32'd4);
    checkOutput("t3_ovf_notyet", 32'(ovf), 32'd0);
    applyStimulus(16'h0105, 1'b0);
    checkOutput("t3_ovf_set", 32'(ovf), 32'd1);
    checkOutput("t3_num_sat", 32'(num), 32'd4);
    checkOutput("t3_noStart5", 32'(start), 32'd0);
    applyStimulus(16'h0106, 1'b1);
    checkOutput("t3_start", 32'(start), 32'd1);
    checkArray("t3", 16'h0101, 16'h0102, 16'h0103, 16'h0104);
    cyc();
    checkOutput("t3_fcnt", 32'(fcnt), 32'd3);
    checkOutput("t3_ovf_hold", 32'(ovf), 32'd1);
    pulseDone();
    checkOutput("t3_ovf_cleared", 32'(ovf), 32'd0);

    // 4: early done_frame ignored, long wait, then done with back-to-back beat
    pulseDone();
    checkOutput("t4_earlyDone_ready", 32'(in_ready), 32'd1);
    done_frame = 1'b1;
    applyStimulus(16'h0707, 1'b0);
    done_frame = 1'b0;
    checkOutput("t4_earlyDone_num", 32'(num), 32'd1);
    applyStimulus(16'h0808, 1'b1);
    checkOutput("t4_start", 32'(start), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      checkOutput("t4_hold_s0", 32'(arr[0]), 32'h0707);
      checkOutput("t4_hold_s1", 32'(arr[1]), 32'h0808);
      checkOutput("t4_hold_num", 32'(num), 32'd2);
      checkOutput("t4_hold_ready", 32'(in_ready), 32'd0);
    end
    checkOutput("t4_fcnt_wrap", 32'(fcnt), 32'd0);
    done_frame = 1'b1;
    in_valid   = 1'b1;
    in_bbox    = 16'h0909;
    in_last    = 1'b1;
    cyc();
    done_frame = 1'b0;
    checkOutput("t4_ready", 32'(in_ready), 32'd1);
    checkOutput("t4_num_clr", 32'(num), 32'd0);
    checkOutput("t4_ovf_clr", 32'(ovf), 32'd0);
    checkArray("t4_clr", 16'h0, 16'h0, 16'h0, 16'h0);
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("t4_nextBeat_start", 32'(start), 32'd1);
    checkOutput("t4_nextBeat_s0", 32'(arr[0]), 32'h0909);
    checkOutput("t4_nextBeat_num", 32'(num), 32'd1);
    cyc();
    checkOutput("t4_fcnt", 32'(fcnt), 32'd1);
    pulseDone();

    // 5: asynchronous reset mid-frame
    applyStimulus(16'h1111, 1'b0);
    applyStimulus(16'h2222, 1'b0);
    #2;
    reset_N = 1'b0;
    #1;
    checkOutput("t5_num_async", 32'(num), 32'd0);
    checkOutput("t5_fcnt_async", 32'(fcnt), 32'd0);
    checkOutput("t5_ready_async", 32'(in_ready), 32'd1);
    checkArray("t5_async", 16'h0, 16'h0, 16'h0, 16'h0);
    cyc();
    reset_N = 1'b1;
    cyc();
    checkOutput("t5_noStart", 32'(start), 32'd0);
    applyStimulus(16'h3333, 1'b1);
    checkOutput("t5_start", 32'(start), 32'd1);
    checkOutput("t5_s0", 32'(arr[0]), 32'h3333);
    checkOutput("t5_num", 32'(num), 32'd1);
    cyc();
    checkOutput("t5_fcnt", 32'(fcnt), 32'd1);
    pulseDone();

    // 6: frame counter wraps with a 2-bit width
    doReset();
    expCnt[0] = 2'd1;
    expCnt[1] = 2'd2;
    expCnt[2] = 2'd3;
    expCnt[3] = 2'd0;
    expCnt[4] = 2'd1;
    for (int f = 0; f < 5; f++) begin
      applyStimulus(16'(16'h4000 + f), 1'b1);
      checkOutput("t6_start", 32'(start), 32'd1);
      cyc();
      checkOutput("t6_fcnt", 32'(fcnt), 32'(expCnt[f]));
      pulseDone();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/oflow_frame_loader.md
# oflow_frame_loader

Upstream feeder for the optical-flow tracking top. Accepts bounding boxes one per cycle over a valid/ready stream and packs them into the per-frame bbox array. Fires a one-cycle `start` toward the tracker, then holds the array stable until the tracker returns `done_frame`. Only after that does it accept the next frame.

## Interface
Parameters:
- `BBOX_VECTOR_SIZE`: default `` `BBOX_VECTOR_SIZE ``. Width of one bbox word.
- `MAX_BBOXES_PER_FRAME`: default `` `MAX_BBOXES_PER_FRAME ``. Array depth.
- `CNT_W`: default `$clog2(MAX_BBOXES_PER_FRAME+1)`. Width of the bbox count.
- `FRAME_CNT_W`: default 16. Width of the frame counter.

Ports:
- `clk`  in  1  Single clock.
- `reset_N`  in  1  Reset; asynchronous, active-low.
- `in_bbox`  in  `BBOX_VECTOR_SIZE`  Bbox word.
- `in_valid`  in  1  `in_bbox` is valid.
- `in_last`  in  1  Qualifies the final beat of a frame.
- `in_ready`  out  1  Loader can accept a beat.
- `bboxes_array_per_frame`  out  `[BBOX_VECTOR_SIZE-1:0] x MAX_BBOXES_PER_FRAME`  Packed frame; slot 0 is the first beat.
- `num_of_bboxes`  out  `CNT_W`  Number of valid slots.
- `start`  out  1  One-cycle pulse: the frame is ready for the tracker.
- `done_frame`  in  1  Tracker has finished the frame.
- `frame_overflow`  out  1  Sticky; the current frame had more than MAX beats.
- `frame_cnt`  out  `FRAME_CNT_W`  Number of frames launched; wraps.

## Operation
State machine with three states: LOAD, LAUNCH, WAIT_DONE. Reset enters LOAD.

LOAD:
- `in_ready` = 1.
- A beat is accepted when `in_valid && in_ready`.
- If count < MAX: write the beat to `slot[count]`, then count++.
- If count == MAX: drop the beat and set `frame_overflow`. Count saturates at MAX.
- An accepted beat with `in_last` = 1 moves the machine to LAUNCH, whether or not that beat was stored.

LAUNCH:
- `in_ready` = 0.
- `start` = 1 for exactly this one cycle.
- `frame_cnt` += 1, wrapping modulo 2^`FRAME_CNT_W`.
- Next state is WAIT_DONE unconditionally.

WAIT_DONE:
- `in_ready` = 0.
- Array, `num_of_bboxes` and `frame_overflow` are held constant.
- When `done_frame` = 1, go to LOAD. On that edge, clear all slots to 0, count to 0 and `frame_overflow` to 0.

Other rules:
- `done_frame` is ignored in LOAD and LAUNCH.
- Unused slots, those at index >= count, always read 0.
- Every frame carries at least one beat. A frame of zero bboxes is not supported.
- `in_last` is ignored when `in_valid` = 0.
- Reset in mid-frame:
  - The partial frame is discarded. State returns to LOAD, all outputs take their reset values, and `start` is not issued.
  - The tracker is reset alongside the loader.

## Timing
Reset values:
- `in_ready` = 1.
- `start` = 0.
- `num_of_bboxes` = 0.
- All slots = 0.
- `frame_overflow` = 0.
- `frame_cnt` = 0.

Outputs are registered except `in_ready`, which decodes combinationally from the state register.

Latency:
- A beat accepted at edge N appears in its slot and in `num_of_bboxes` after edge N.
- Last beat accepted at edge N: `start` is high during cycle N+1 and the array is already final in that cycle.
- `done_frame` sampled at edge M: after M, `in_ready` = 1 and the array is cleared. The next beat can therefore be accepted at edge M+1.

Minimum spacing between `start` pulses is the frame length + 2 cycles.

## Structure
Package `oflow_loader_pkg` holds:
- the state enum `loader_state_t` {LOAD, LAUNCH, WAIT_DONE};
- `bbox_t` (logic `[BBOX_VECTOR_SIZE-1:0]`).

Width constants come from `oflow_core_define.sv`.

One sub-module, `oflow_bbox_buffer`:
- MAX-entry register array with `wr_en`, `wr_idx`, `wr_data` and a synchronous `clr`;
- exposes all entries in parallel.

The FSM, count and frame counter live in `oflow_frame_loader`.

## Test plan
Benches use MAX_BBOXES_PER_FRAME = 4.

1. Three beats A, B, C, with `in_last` on C and no stalls:
   - `start` pulses one cycle after C.
   - Array = {A, B, C, 0}; `num_of_bboxes` = 3; `frame_cnt` = 1.
   - `in_ready` = 0 until `done_frame`.
2. `in_valid` toggled 1,0,1,0 while beats arrive:
   - Only the valid beats are stored, in order, with no gaps in slot indices.
3. Six beats in one frame:
   - Slots hold beats 1-4; `num_of_bboxes` = 4.
   - `frame_overflow` = 1 after beat 5.
   - `start` still issues after beat 6.
4. `done_frame` pulsed during LOAD, then 10 cycles of WAIT_DONE, then `done_frame`:
   - The early pulse is ignored and the array holds through the 10 cycles.
   - After the accepted `done_frame`: all slots 0, `num_of_bboxes` = 0, `frame_overflow` = 0.
   - A beat presented in the next cycle is accepted.
5. `reset_N` asserted after two beats of a frame:
   - Outputs are at reset values immediately (asynchronous) and no `start` occurs.
   - After release, a fresh one-beat frame launches with `frame_cnt` = 1.
6. Run with `FRAME_CNT_W` = 2 for five frames:
   - `frame_cnt` sequence is 1, 2, 3, 0, 1.
